// File: rtl/counter_step_sequencer.sv
// Arbitrates two {dir, steps} requesters round-robin and turns each command into enable pulses for the 2-bit up/down counter.
// Optional COUNT_CHECK_EN: compares ctr_count against the shadow copy in DONE and raises a sticky mismatch flag.
module counter_step_sequencer #(
    parameter int STEP_W  = 4,
    parameter int GAP_CYC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_dir,
    input  logic [STEP_W-1:0] req0_steps,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_dir,
    input  logic [STEP_W-1:0] req1_steps,
    output logic              req1_ready,
    output logic [1:0]        ctr_enable,
    input  logic [1:0]        ctr_count,
    output logic              busy,
    output logic              done,
    output logic              done_id,
    output logic [1:0]        shadow_count,
    output logic              mismatch,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_dir;
    logic              r_id;
    logic              r_prio1;
    logic [STEP_W-1:0] r_remaining;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [1:0]        r_shadow;

    logic              w_idle;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_accept;
    logic [STEP_W-1:0] w_acc_steps;

    // A command transfers on a clock edge where reqN_valid & reqN_ready; ready is only raised in IDLE,
    // for at most one requester, and the requester must hold its fields stable while valid is high.
    assign w_idle      = (r_state == S_IDLE);
    assign w_grant0    = req0_valid & (~req1_valid | ~r_prio1);
    assign w_grant1    = req1_valid & (~req0_valid | r_prio1);
    assign req0_ready  = w_idle & w_grant0;
    assign req1_ready  = w_idle & w_grant1;
    assign w_accept    = req0_ready | req1_ready;
    assign w_acc_steps = req1_ready ? req1_steps : req0_steps;

    always_comb begin
        w_next_state = r_state;
        ctr_enable   = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = (w_acc_steps != '0) ? S_STEP : S_DONE;
                end
            end
            S_STEP: begin
                ctr_enable = r_dir ? 2'b10 : 2'b01;
                if (r_remaining == STEP_W'(1)) begin
                    w_next_state = S_DONE;
                end else if (GAP_CYC > 0) begin
                    w_next_state = S_GAP;
                end else begin
                    w_next_state = S_STEP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_next_state = S_STEP;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_dir       <= 1'b0;
            r_id        <= 1'b0;
            r_prio1     <= 1'b0;
            r_remaining <= '0;
            r_gap_cnt   <= '0;
            r_shadow    <= 2'b00;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dir       <= req1_ready ? req1_dir : req0_dir;
                        r_id        <= req1_ready;
                        r_prio1     <= req0_ready;
                        r_remaining <= w_acc_steps;
                    end
                end
                S_STEP: begin
                    // The counter moves on this same edge, so the shadow tracks it cycle for cycle.
                    r_shadow    <= r_dir ? (r_shadow - 2'd1) : (r_shadow + 2'd1);
                    r_remaining <= r_remaining - 1'b1;
                    r_gap_cnt   <= GAP_W'(GAP_CYC - 1);
                end
                S_GAP: begin
                    r_gap_cnt <= r_gap_cnt - 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy         = ~w_idle;
    assign done         = (r_state == S_DONE);
    assign done_id      = done & r_id;
    assign shadow_count = r_shadow;
    assign dbg_state    = r_state;

`ifdef COUNT_CHECK_EN
    logic r_mismatch;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mismatch <= 1'b0;
        end else if ((r_state == S_DONE) && (ctr_count != r_shadow)) begin
            r_mismatch <= 1'b1;
        end
    end

    assign mismatch = r_mismatch;
`else
    logic w_unused_ctr_count;

    assign w_unused_ctr_count = ^ctr_count;
    assign mismatch           = 1'b0;
`endif

endmodule

// File: tb/tb_counter_step_sequencer.sv
// Bench for counter_step_sequencer: two instances (GAP_CYC=0 and GAP_CYC=2), each with a counter stand-in and a schedule-based model.
// Directed command lists drive the requesters; literal checks pin latency, ordering, wrap and reset-abort.
module tb_counter_step_sequencer;

    localparam int STEP_W = 4;
    localparam int BUDGET = 300;

    typedef struct packed {
        logic [1:0] en;
        logic       done;
        logic       id;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    bit   chk_on = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic              v0 [2];
    logic              d0 [2];
    logic [STEP_W-1:0] s0 [2];
    logic              v1 [2];
    logic              d1 [2];
    logic [STEP_W-1:0] s1 [2];
    logic [1:0]        bad [2];

    logic              rdy0 [2];
    logic              rdy1 [2];
    logic [1:0]        en [2];
    logic              bsy [2];
    logic              dn [2];
    logic              did [2];
    logic [1:0]        shd [2];
    logic              mis [2];
    logic [1:0]        dbg [2];
    logic [1:0]        cnt_s [2];
    int                done_cnt_s [2];
    int                pulse_cnt_s [2];
    int                last_done_cyc_s [2];
    logic [7:0]        done_hist_s [2];
    int                mv [2];
    int                mf [2];

    int n_vec = 0;
    int n_fail = 0;
    int acc_cyc = 0;
    logic [STEP_W:0] q0 [$];
    logic [STEP_W:0] q1 [$];

    for (genvar i = 0; i < 2; i++) begin : g_dut
        localparam int G = (i == 0) ? 0 : 2;
        logic [1:0] cnt;
        ent_t       sched [$];
        logic [1:0] m_shadow = 2'b00;
        bit         m_ptr1 = 1'b0;
        bit         m_mis = 1'b0;
        int         m_vec = 0;
        int         m_fail = 0;
        int         done_cnt = 0;
        int         pulse_cnt = 0;
        int         last_done_cyc = 0;
        logic [7:0] done_hist = 8'd0;

        counter_step_sequencer #(.STEP_W(STEP_W), .GAP_CYC(G)) u_dut (
            .clk          (clk),
            .reset        (reset),
            .req0_valid   (v0[i]),
            .req0_dir     (d0[i]),
            .req0_steps   (s0[i]),
            .req0_ready   (rdy0[i]),
            .req1_valid   (v1[i]),
            .req1_dir     (d1[i]),
            .req1_steps   (s1[i]),
            .req1_ready   (rdy1[i]),
            .ctr_enable   (en[i]),
            .ctr_count    (cnt ^ bad[i]),
            .busy         (bsy[i]),
            .done         (dn[i]),
            .done_id      (did[i]),
            .shadow_count (shd[i]),
            .mismatch     (mis[i]),
            .dbg_state    (dbg[i])
        );

        // Stand-in for the 2-bit Moore up/down counter.
        always @(posedge clk) begin
            if (reset) cnt <= 2'b00;
            else if (en[i] == 2'b01) cnt <= cnt + 2'd1;
            else if (en[i] == 2'b10) cnt <= cnt - 2'd1;
        end

        assign cnt_s[i]           = cnt;
        assign done_cnt_s[i]      = done_cnt;
        assign pulse_cnt_s[i]     = pulse_cnt;
        assign last_done_cyc_s[i] = last_done_cyc;
        assign done_hist_s[i]     = done_hist;
        assign mv[i]              = m_vec;
        assign mf[i]              = m_fail;

        task automatic mchk(input string nm, input logic [7:0] act, input logic [7:0] exp);
            m_vec++;
            if (act !== exp) begin
                m_fail++;
                $display("FAIL g%0d %s: got %0h expected %0h (cycle %0d)", i, nm, act, exp, cyc);
            end
        endtask

        always @(negedge clk) begin
            ent_t            cur;
            ent_t            e;
            bit              idle;
            bit              g0;
            bit              g1;
            logic            dir_l;
            logic [STEP_W-1:0] st;
            idle = (sched.size() == 0);
            cur  = idle ? ent_t'(4'd0) : sched[0];
            g0   = idle && (v0[i] === 1'b1) && (v1[i] !== 1'b1 || !m_ptr1);
            g1   = idle && (v1[i] === 1'b1) && (v0[i] !== 1'b1 || m_ptr1);
            if (dn[i] === 1'b1) begin
                done_cnt++;
                last_done_cyc = cyc;
                done_hist = {done_hist[6:0], did[i]};
            end
            if (en[i] == 2'b01 || en[i] == 2'b10) pulse_cnt++;
            if (chk_on) begin
                mchk("ctr_enable", 8'(en[i]), 8'(cur.en));
                mchk("busy", 8'(bsy[i]), 8'(!idle));
                mchk("done", 8'(dn[i]), 8'(cur.done));
                if (cur.done) mchk("done_id", 8'(did[i]), 8'(cur.id));
                mchk("shadow_count", 8'(shd[i]), 8'(m_shadow));
                mchk("ctr_count", 8'(cnt), 8'(m_shadow));
                mchk("req0_ready", 8'(rdy0[i]), 8'(g0));
                mchk("req1_ready", 8'(rdy1[i]), 8'(g1));
                mchk("mismatch", 8'(mis[i]), 8'(m_mis));
            end
            if (reset) begin
                sched.delete();
                m_shadow = 2'b00;
                m_ptr1   = 1'b0;
                m_mis    = 1'b0;
            end else if (!idle) begin
                e = sched.pop_front();
                if (e.en == 2'b01) m_shadow = m_shadow + 2'd1;
                if (e.en == 2'b10) m_shadow = m_shadow - 2'd1;
`ifdef COUNT_CHECK_EN
                if (e.done && ((cnt ^ bad[i]) != m_shadow)) m_mis = 1'b1;
`endif
            end else if (g0 || g1) begin
                dir_l  = g1 ? d1[i] : d0[i];
                st     = g1 ? s1[i] : s0[i];
                m_ptr1 = g0;
                for (int k = 0; k < int'(st); k++) begin
                    sched.push_back('{en: (dir_l ? 2'b10 : 2'b01), done: 1'b0, id: 1'b0});
                    if (k < int'(st) - 1) begin
                        for (int j = 0; j < G; j++) sched.push_back('{en: 2'b00, done: 1'b0, id: 1'b0});
                    end
                end
                sched.push_back('{en: 2'b00, done: 1'b1, id: g1});
            end
        end
    end

    task automatic check_m(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Presents q0/q1 on instance inst until drained, then waits for n_done completions.
    task automatic run_cmds(input int inst, input int n_done);
        int base;
        int budget;
        base   = done_cnt_s[inst];
        budget = 0;
        while ((q0.size() > 0 || q1.size() > 0) && budget < BUDGET) begin
            v0[inst] = (q0.size() > 0);
            if (q0.size() > 0) {d0[inst], s0[inst]} = q0[0];
            v1[inst] = (q1.size() > 0);
            if (q1.size() > 0) {d1[inst], s1[inst]} = q1[0];
            @(negedge clk);
            if (rdy0[inst] === 1'b1) begin
                void'(q0.pop_front());
                acc_cyc = cyc;
            end
            if (rdy1[inst] === 1'b1) begin
                void'(q1.pop_front());
                acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
            budget++;
        end
        v0[inst] = 1'b0;
        v1[inst] = 1'b0;
        while (done_cnt_s[inst] < base + n_done && budget < BUDGET) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check_m("run_cmds within budget", 32'(budget < BUDGET), 32'd1);
        q0.delete();
        q1.delete();
    endtask

    initial begin
        int p0;
        int dc;
        int budget;
        for (int k = 0; k < 2; k++) begin
            v0[k] = 1'b0; d0[k] = 1'b0; s0[k] = '0;
            v1[k] = 1'b0; d1[k] = 1'b0; s1[k] = '0;
            bad[k] = 2'b00;
        end
        reset = 1'b1;
        @(posedge clk);
        chk_on = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check_m("reset ctr_enable", 32'(en[0]), 32'd0);
        check_m("reset busy", 32'(bsy[0]), 32'd0);
        check_m("reset done", 32'(dn[0]), 32'd0);
        check_m("reset shadow", 32'(shd[0]), 32'd0);
        check_m("reset mismatch", 32'(mis[0]), 32'd0);
        check_m("reset ready0", 32'(rdy0[0]), 32'd0);
        check_m("reset ready1", 32'(rdy1[0]), 32'd0);
        @(posedge clk);
        #1;

        // req0 up 3: three back-to-back pulses, done 4 cycles after accept.
        p0 = pulse_cnt_s[0];
        q0.push_back({1'b0, 4'd3});
        run_cmds(0, 1);
        check_m("up3 latency", 32'(last_done_cyc_s[0] - acc_cyc), 32'd4);
        check_m("up3 pulses", 32'(pulse_cnt_s[0] - p0), 32'd3);
        check_m("up3 count", 32'(cnt_s[0]), 32'd3);
        check_m("up3 done_id", 32'(done_hist_s[0][0]), 32'd0);

        q0.push_back({1'b0, 4'd1});
        run_cmds(0, 1);
        check_m("wrap 3+1", 32'(cnt_s[0]), 32'd0);

        // req1 down 1 from 0 wraps to 3.
        q1.push_back({1'b1, 4'd1});
        run_cmds(0, 1);
        check_m("down1 latency", 32'(last_done_cyc_s[0] - acc_cyc), 32'd2);
        check_m("down1 count", 32'(cnt_s[0]), 32'd3);
        check_m("down1 shadow", 32'(shd[0]), 32'd3);
        check_m("down1 done_id", 32'(done_hist_s[0][0]), 32'd1);
        q0.push_back({1'b0, 4'd1});
        run_cmds(0, 1);
        check_m("up1 back to 0", 32'(cnt_s[0]), 32'd0);

        // Round robin: after reset req0 wins, then req1, then req0's follow-up.
        pulse_reset();
        q0.push_back({1'b0, 4'd1});
        q0.push_back({1'b0, 4'd2});
        q1.push_back({1'b1, 4'd1});
        run_cmds(0, 3);
        check_m("rr order", 32'(done_hist_s[0][2:0]), 32'd2);
        check_m("rr count", 32'(cnt_s[0]), 32'd2);

        // Zero steps: no pulse, done one cycle after accept.
        p0 = pulse_cnt_s[0];
        q1.push_back({1'b0, 4'd0});
        run_cmds(0, 1);
        check_m("zero latency", 32'(last_done_cyc_s[0] - acc_cyc), 32'd1);
        check_m("zero pulses", 32'(pulse_cnt_s[0] - p0), 32'd0);
        check_m("zero count", 32'(cnt_s[0]), 32'd2);

        // GAP_CYC=2 instance: pulse, 00, 00, pulse, done.
        p0 = pulse_cnt_s[1];
        q0.push_back({1'b0, 4'd2});
        run_cmds(1, 1);
        check_m("gap latency", 32'(last_done_cyc_s[1] - acc_cyc), 32'd5);
        check_m("gap pulses", 32'(pulse_cnt_s[1] - p0), 32'd2);
        check_m("gap count", 32'(cnt_s[1]), 32'd2);

        // Reset during a 5-step command aborts it.
        v0[0] = 1'b1; d0[0] = 1'b0; s0[0] = 4'd5;
        budget = 0;
        @(negedge clk);
        while (rdy0[0] !== 1'b1 && budget < BUDGET) begin
            @(negedge clk);
            budget++;
        end
        check_m("abort accept within budget", 32'(budget < BUDGET), 32'd1);
        @(posedge clk);
        #1 v0[0] = 1'b0;
        @(posedge clk);
        #1;
        dc = done_cnt_s[0];
        pulse_reset();
        @(negedge clk);
        check_m("abort ctr_enable", 32'(en[0]), 32'd0);
        check_m("abort busy", 32'(bsy[0]), 32'd0);
        check_m("abort count", 32'(cnt_s[0]), 32'd0);
        check_m("abort shadow", 32'(shd[0]), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        check_m("abort no done", 32'(done_cnt_s[0]), 32'(dc));

`ifdef COUNT_CHECK_EN
        bad[0] = 2'b01;
        q0.push_back({1'b0, 4'd2});
        run_cmds(0, 1);
        check_m("mismatch set", 32'(mis[0]), 32'd1);
        bad[0] = 2'b00;
        q0.push_back({1'b0, 4'd1});
        run_cmds(0, 1);
        check_m("mismatch sticky", 32'(mis[0]), 32'd1);
        pulse_reset();
        @(negedge clk);
        check_m("mismatch cleared", 32'(mis[0]), 32'd0);
        @(posedge clk);
        #1;
`endif

        repeat (2) @(posedge clk);
        #1;
        n_vec  += mv[0] + mv[1];
        n_fail += mf[0] + mf[1];
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
